// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. Turns hps_io PS/2 key events into
//   held-key latches, merges them with the two joysticks, applies the
//   screen-rotation remap, per-player autofire and coin-pulse stretching.
//   All outputs are registered.
// Ports
//   clk_sys, reset            clock, synchronous active-high reset
//   ps2_key[64:0]             hps_io key bus ([64] toggle, [63:24] long code, [23:0] scan bytes)
//   joystick_0/1[15:0]        [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start [7]coin
//   vblank                    autofire timebase
//   rotate                    1 = rotate directions for a horizontal display
//   autofire_en[1:0]          per-player autofire enable
//   p1_ctrl/p2_ctrl[5:0]      {bomb,fire,right,left,down,up}
//   start1, start2, coin      start buttons and stretched coin
module arcade_input_mapper #(
    parameter int          NPLAYERS        = 1,
    parameter int          AUTOFIRE_FRAMES = 2,
    parameter logic [15:0] COIN_PULSE      = 16'd40000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        vblank,
    input  logic        rotate,
    input  logic [1:0]  autofire_en,
    output logic [5:0]  p1_ctrl,
    output logic [5:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin
);

    localparam logic [3:0] AF_LAST = 4'(AUTOFIRE_FRAMES - 1);

    // Joystick bits reordered into the {bomb,fire,right,left,down,up} layout.
    function automatic logic [5:0] jmap(input logic [15:0] j);
        return {j[5], j[4], j[0], j[1], j[2], j[3]};
    endfunction

    // Rotated: up<-left, down<-right, left<-down, right<-up.
    function automatic logic [5:0] rot(input logic [5:0] r, input logic en);
        return en ? {r[5], r[4], r[0], r[1], r[3], r[2]} : r;
    endfunction

    logic       toggle_q;
    logic [5:0] k1_q, k1_d, k2_q, k2_d;
    logic       ks1_q, ks1_d, ks2_q, ks2_d, kcoin_q, kcoin_d;
    logic       vblank_q;
    logic [1:0][3:0] afcnt_q, afcnt_d;
    logic [1:0] phase_q, phase_d, fire_raw_q, fire_raw, fire_out;
    logic       coin_raw, coin_raw_q;
    logic [15:0] ccnt_q, ccnt_d;
    logic [5:0] raw1, raw2, out1, out2;
    logic       key_evt, pressed, ext;
    logic [7:0] code;

    logic unused_ok;
    assign unused_ok = ^{joystick_0[15:8], joystick_1[15:8]};

    // Key decode: break prefix F0 in byte 1, E0 sits in byte 1 (make) or byte 2 (break).
    always_comb begin
        key_evt = (ps2_key[64] != toggle_q) && (ps2_key[63:24] == 40'd0);
        pressed = ps2_key[15:8] != 8'hF0;
        ext     = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        code    = ps2_key[7:0];
        k1_d    = k1_q;
        k2_d    = k2_q;
        ks1_d   = ks1_q;
        ks2_d   = ks2_q;
        kcoin_d = kcoin_q;
        if (key_evt) begin
            case (code)
                8'h75: k1_d[0] = pressed;
                8'h72: k1_d[1] = pressed;
                8'h6B: k1_d[2] = pressed;
                8'h74: k1_d[3] = pressed;
                8'h14: k1_d[5] = pressed;
                8'h29: if (!ext) k1_d[4] = pressed;
                8'h2D: if (!ext) k2_d[0] = pressed;
                8'h2B: if (!ext) k2_d[1] = pressed;
                8'h23: if (!ext) k2_d[2] = pressed;
                8'h34: if (!ext) k2_d[3] = pressed;
                8'h1C: if (!ext) k2_d[4] = pressed;
                8'h1B: if (!ext) k2_d[5] = pressed;
                8'h05: if (!ext) ks1_d   = pressed;
                8'h06: if (!ext) ks2_d   = pressed;
                8'h04: if (!ext) kcoin_d = pressed;
                default: ;
            endcase
        end
    end

    // Merge keys with joysticks; single-player mode folds the P2 set into P1.
    always_comb begin
        raw1 = k1_q | jmap(joystick_0);
        raw2 = k2_q | jmap(joystick_1);
        if (NPLAYERS == 1) begin
            raw1 = raw1 | raw2;
            raw2 = 6'd0;
        end
        coin_raw = kcoin_q | joystick_0[7] | joystick_1[7];
        fire_raw = {raw2[4], raw1[4]};
    end

    // Autofire: phase toggles every AUTOFIRE_FRAMES vblank edges; a fresh
    // press restarts the cycle with phase=1 so the first shot is immediate.
    // The output uses the next phase so the press itself fires this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            afcnt_d[p] = afcnt_q[p];
            phase_d[p] = phase_q[p];
            if (fire_raw[p] && !fire_raw_q[p]) begin
                afcnt_d[p] = 4'd0;
                phase_d[p] = 1'b1;
            end else if (vblank && !vblank_q) begin
                if (afcnt_q[p] == AF_LAST) begin
                    afcnt_d[p] = 4'd0;
                    phase_d[p] = ~phase_q[p];
                end else begin
                    afcnt_d[p] = afcnt_q[p] + 4'd1;
                end
            end
            fire_out[p] = autofire_en[p] ? (fire_raw[p] & phase_d[p]) : fire_raw[p];
        end
        out1    = rot(raw1, rotate);
        out2    = rot(raw2, rotate);
        out1[4] = fire_out[0];
        out2[4] = fire_out[1];
    end

    // Coin stretch: each rising edge (re)loads the counter.
    always_comb begin
        ccnt_d = ccnt_q;
        if (coin_raw && !coin_raw_q) ccnt_d = COIN_PULSE;
        else if (ccnt_q != 16'd0)    ccnt_d = ccnt_q - 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q   <= 1'b0;
            k1_q       <= '0;
            k2_q       <= '0;
            ks1_q      <= 1'b0;
            ks2_q      <= 1'b0;
            kcoin_q    <= 1'b0;
            vblank_q   <= 1'b0;
            afcnt_q    <= '0;
            phase_q    <= '0;
            fire_raw_q <= '0;
            coin_raw_q <= 1'b0;
            ccnt_q     <= '0;
            p1_ctrl    <= '0;
            p2_ctrl    <= '0;
            start1     <= 1'b0;
            start2     <= 1'b0;
            coin       <= 1'b0;
        end else begin
            toggle_q   <= ps2_key[64];
            k1_q       <= k1_d;
            k2_q       <= k2_d;
            ks1_q      <= ks1_d;
            ks2_q      <= ks2_d;
            kcoin_q    <= kcoin_d;
            vblank_q   <= vblank;
            afcnt_q    <= afcnt_d;
            phase_q    <= phase_d;
            fire_raw_q <= fire_raw;
            coin_raw_q <= coin_raw;
            ccnt_q     <= ccnt_d;
            p1_ctrl    <= out1;
            p2_ctrl    <= out2;
            start1     <= ks1_q | joystick_0[6];
            start2     <= ks2_q | joystick_1[6];
            coin       <= (ccnt_d != 16'd0) | coin_raw;
        end
    end

endmodule
